// File: rtl/user_code_loader.sv
// Byte-stream loader for the i281 user code store: frames LEN, 2*N data bytes, CHK,
// assembles high-byte-first instruction words and strobes them into code memory.
module user_code_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [AW:0]   word_count;
    logic [7:0]    hi_byte;
    logic [7:0]    sum;
    logic [AW-1:0] addr;
    logic          xfer;
    logic          arm;
    logic          len_bad;
    logic          last_word;
    logic [AW:0]   len_words;

    assign xfer      = rx_valid && rx_ready;
    assign len_bad   = {1'b0, rx_data} > DEPTH_W;
    assign len_words = (rx_data == 8'd0) ? (AW+1)'(DEPTH) : (AW+1)'(rx_data);
    assign last_word = (words_loaded + (AW+1)'(1)) == word_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // done and err are simply the terminal states, so they stay sticky until re-armed
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        arm        = 1'b0;
        unique case (state)
            S_IDLE, S_DONE, S_ERR: begin
                done = (state == S_DONE);
                err  = (state == S_ERR);
                if (start) begin
                    arm        = 1'b1;
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                busy = 1'b1;
                if (xfer) state_next = len_bad ? S_ERR : S_HI;
            end
            S_HI: begin
                busy = 1'b1;
                if (xfer) state_next = S_LO;
            end
            S_LO: begin
                busy = 1'b1;
                if (xfer) state_next = last_word ? S_CHK : S_HI;
            end
            S_CHK: begin
                busy = 1'b1;
                if (xfer) state_next = (rx_data == sum) ? S_DONE : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
        rx_ready = busy;
    end

    // Word assembly, checksum and the registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count   <= '0;
            hi_byte      <= '0;
            sum          <= '0;
            addr         <= '0;
            words_loaded <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            wr_en <= 1'b0;
            if (arm) begin
                sum          <= '0;
                addr         <= '0;
                words_loaded <= '0;
            end
            if (xfer) begin
                case (state)
                    S_LEN: word_count <= len_words;
                    S_HI: begin
                        hi_byte <= rx_data;
                        sum     <= sum + rx_data;
                    end
                    S_LO: begin
                        wr_en        <= 1'b1;
                        wr_addr      <= addr;
                        wr_data      <= {hi_byte, rx_data};
                        addr         <= addr + AW'(1);
                        words_loaded <= words_loaded + (AW+1)'(1);
                        sum          <= sum + rx_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_user_code_loader.sv
// Randomized self-checking bench for user_code_loader; expected writes and status come
// from a frame-level model (word list, byte sum, length rule).
module tb_user_code_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;

    logic [AW+15:0] obs[$];
    logic [15:0]    frame_words[$];

    user_code_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy),
        .done(done),
        .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) obs.push_back({wr_addr, wr_data});
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] frame_sum();
        int s = 0;
        foreach (frame_words[i]) s += int'(frame_words[i][15:8]) + int'(frame_words[i][7:0]);
        return 8'(s % 256);
    endfunction

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int waited;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < 50) begin
            stall_cycles++;
            waited++;
            @(negedge clk);
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_ready_timeout: rx_ready=%b required 1", rx_ready);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len_byte, input int nw, input logic [7:0] chk,
                              input int gap);
        send_byte(len_byte, gap);
        for (int i = 0; i < nw; i++) begin
            send_byte(frame_words[i][15:8], gap);
            send_byte(frame_words[i][7:0], gap);
        end
        send_byte(chk, gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready, wr_en, wr_addr, wr_data, busy, done, err, words_loaded} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b we=%b a=%0d d=%h busy=%b done=%b err=%b wl=%0d, required all 0",
                     rx_ready, wr_en, wr_addr, wr_data, busy, done, err, words_loaded);
        end
        reset    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        checks++;
        if (rx_ready !== 1'b0 || busy !== 1'b0 || obs.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_no_accept: rdy=%b busy=%b writes=%0d, required 0 0 0",
                     rx_ready, busy, obs.size());
        end
    endtask

    task automatic test_full_load();
        int first_high;
        frame_words.delete();
        for (int i = 0; i < DEPTH; i++) frame_words.push_back(16'($urandom));
        obs.delete();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || rx_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL arm_latency: busy=%b rdy=%b, required 1 1", busy, rx_ready);
        end
        stall_cycles = 0;
        send_frame(8'h00, DEPTH, frame_sum(), 0);
        checks++;
        if (stall_cycles != 0) begin
            errors++;
            $display("[TB] FAIL full_throughput: stall cycles %0d, required 0", stall_cycles);
        end
        checks++;
        if (obs.size() != DEPTH) begin
            errors++;
            $display("[TB] FAIL full_write_count: got %0d, required %0d", obs.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < obs.size(); i++) begin
            checks++;
            if (obs[i] !== {AW'(i), frame_words[i]}) begin
                errors++;
                $display("[TB] FAIL full_write[%0d]: got a=%0d d=%h, required a=%0d d=%h",
                         i, obs[i][AW+15:16], obs[i][15:0], i, frame_words[i]);
            end
        end
        first_high = -1;
        for (int i = obs.size() - 1; i >= 0; i--) if (obs[i][AW+15]) first_high = i;
        checks++;
        if (first_high != DEPTH / 2) begin
            errors++;
            $display("[TB] FAIL full_bank_switch: first high-bank write index %0d, required %0d",
                     first_high, DEPTH / 2);
        end
        checks++;
        if (words_loaded !== (AW+1)'(DEPTH) || done !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_status: wl=%0d done=%b err=%b busy=%b, required %0d 1 0 0",
                     words_loaded, done, err, busy, DEPTH);
        end
    endtask

    task automatic test_checksum();
        logic [7:0] chk_list[2];
        logic       exp_ok;
        chk_list[0] = 8'hD5;
        chk_list[1] = 8'hD4;
        for (int t = 0; t < 2; t++) begin
            frame_words.delete();
            frame_words.push_back(16'h3000);
            frame_words.push_back(16'hA005);
            exp_ok = (chk_list[t] == frame_sum());
            obs.delete();
            pulse_start();
            send_frame(8'h02, 2, chk_list[t], 0);
            repeat (2) @(negedge clk);
            checks++;
            if (obs.size() != 2 || obs[0] !== {AW'(0), 16'h3000} || obs[1] !== {AW'(1), 16'hA005}) begin
                errors++;
                $display("[TB] FAIL chk%0d_writes: got %0d writes (first %h), required (0,3000) (1,a005)",
                         t, obs.size(), (obs.size() > 0) ? obs[0] : '0);
            end
            checks++;
            if (done !== exp_ok || err !== !exp_ok || rx_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL chk%0d_status: done=%b err=%b rdy=%b, required %b %b 0",
                         t, done, err, rx_ready, exp_ok, !exp_ok);
            end
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] len_byte;
        int         nw;
        logic       exp_bad;
        len_byte = 8'h21;
        nw       = (len_byte == 8'h00) ? DEPTH : int'(len_byte);
        exp_bad  = (nw > DEPTH);
        obs.delete();
        pulse_start();
        send_byte(len_byte, 0);
        checks++;
        if (err !== exp_bad || done !== 1'b0 || rx_ready !== !exp_bad) begin
            errors++;
            $display("[TB] FAIL badlen_status: err=%b done=%b rdy=%b, required %b 0 %b",
                     err, done, rx_ready, exp_bad, !exp_bad);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (obs.size() != 0) begin
            errors++;
            $display("[TB] FAIL badlen_no_write: got %0d writes, required 0", obs.size());
        end
    endtask

    task automatic test_stall();
        logic exp_ok;
        frame_words.delete();
        frame_words.push_back(16'h8C04);
        exp_ok = (8'h90 == frame_sum());
        obs.delete();
        pulse_start();
        send_byte(8'h01, 5);
        repeat (5) @(negedge clk);
        pulse_start();
        send_byte(8'h8C, 5);
        pulse_start();
        repeat (5) @(negedge clk);
        send_byte(8'h04, 5);
        pulse_start();
        send_byte(8'h90, 5);
        repeat (2) @(negedge clk);
        checks++;
        if (obs.size() != 1 || obs[0] !== {AW'(0), 16'h8C04}) begin
            errors++;
            $display("[TB] FAIL stall_write: got %0d writes (first %h), required one (0,8c04)",
                     obs.size(), (obs.size() > 0) ? obs[0] : '0);
        end
        checks++;
        if (done !== exp_ok || err !== !exp_ok || words_loaded !== (AW+1)'(1)) begin
            errors++;
            $display("[TB] FAIL stall_status: done=%b err=%b wl=%0d, required %b %b 1",
                     done, err, words_loaded, exp_ok, !exp_ok);
        end
    endtask

    task automatic test_reset_midload();
        frame_words.delete();
        for (int i = 0; i < 4; i++) frame_words.push_back(16'($urandom));
        obs.delete();
        pulse_start();
        send_byte(8'h04, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(frame_words[i][15:8], 0);
            send_byte(frame_words[i][7:0], 0);
        end
        send_byte(frame_words[3][15:8], 0);
        reset = 1'b1;
        #1;
        checks++;
        if ({rx_ready, wr_en, wr_addr, wr_data, busy, done, err, words_loaded} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: rdy=%b we=%b a=%0d d=%h busy=%b wl=%0d, required all 0",
                     rx_ready, wr_en, wr_addr, wr_data, busy, words_loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs.size() != 3 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_writes: got %0d writes busy=%b, required 3 0", obs.size(), busy);
        end
        frame_words.delete();
        for (int i = 0; i < 5; i++) frame_words.push_back(16'($urandom));
        obs.delete();
        pulse_start();
        send_frame(8'h05, 5, frame_sum(), 2);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= obs.size() || obs[i] !== {AW'(i), frame_words[i]}) begin
                errors++;
                $display("[TB] FAIL reload_write[%0d]: got %h, required a=%0d d=%h",
                         i, (i < obs.size()) ? obs[i] : '0, i, frame_words[i]);
            end
        end
        checks++;
        if (obs.size() != 5 || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_status: writes=%0d done=%b err=%b, required 5 1 0",
                     obs.size(), done, err);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] len_byte;
        logic [7:0] chk;
        int         nw;
        logic       exp_bad;
        logic       exp_ok;
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(9, 0) == 0) len_byte = 8'($urandom_range(255, DEPTH + 1));
            else len_byte = 8'($urandom_range(DEPTH, 0));
            nw      = (len_byte == 8'h00) ? DEPTH : int'(len_byte);
            exp_bad = (nw > DEPTH);
            frame_words.delete();
            if (!exp_bad) for (int i = 0; i < nw; i++) frame_words.push_back(16'($urandom));
            chk = frame_sum();
            if ($urandom_range(1, 0) == 1) chk = chk ^ 8'($urandom_range(255, 1));
            exp_ok = !exp_bad && (chk == frame_sum());
            obs.delete();
            pulse_start();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || words_loaded !== '0) begin
                errors++;
                $display("[TB] FAIL b2b%0d_arm: busy=%b done=%b err=%b wl=%0d, required 1 0 0 0",
                         f, busy, done, err, words_loaded);
            end
            if (exp_bad) send_byte(len_byte, 3);
            else send_frame(len_byte, nw, chk, 3);
            @(negedge clk);
            checks++;
            if (obs.size() != (exp_bad ? 0 : nw)) begin
                errors++;
                $display("[TB] FAIL b2b%0d_count: got %0d writes, required %0d",
                         f, obs.size(), exp_bad ? 0 : nw);
            end
            for (int i = 0; i < obs.size() && i < frame_words.size(); i++) begin
                checks++;
                if (obs[i] !== {AW'(i), frame_words[i]}) begin
                    errors++;
                    $display("[TB] FAIL b2b%0d_write[%0d]: got %h, required a=%0d d=%h",
                             f, i, obs[i], i, frame_words[i]);
                end
            end
            checks++;
            if (done !== exp_ok || err !== !exp_ok || busy !== 1'b0 ||
                words_loaded !== (AW+1)'(exp_bad ? 0 : nw)) begin
                errors++;
                $display("[TB] FAIL b2b%0d_status: done=%b err=%b busy=%b wl=%0d, required %b %b 0 %0d",
                         f, done, err, busy, words_loaded, exp_ok, !exp_ok, exp_bad ? 0 : nw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_checksum();
        test_bad_length();
        test_stall();
        test_reset_midload();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
